button_step_gen: RTL and testbench

Conditions a raw mechanical pushbutton into a clean single-cycle step pulse that drives the `en` input of the lab binary counter. It sits directly upstream of the counter: `btn_in` comes from the board pin and `en_out` feeds the counter enable. The signal path is synchronizer, then debounce FSM, then one-pulse generator, with optional hold-to-repeat.

---
 rtl/button_step_gen.sv | 171 +++++++++++++++++
 tb/tb_button_step_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/button_step_gen.sv
// Pushbutton conditioner: synchronizer, debounce FSM and one-pulse step output for the counter enable.
// Optional hold-to-repeat pulses are built when BTN_AUTOREPEAT_EN is defined.
module button_step_gen #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DB_W            = 20,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000,
   parameter int RPT_W           = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic en_out,
   output logic btn_level
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   btn_s;
   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [DB_W-1:0]        db_cnt_r;
   logic [DB_W-1:0]        db_cnt_nxt_s;
   logic                   press_acc_s;
   logic                   rpt_pulse_s;

   // Input synchronizer shift chain; btn_in is sampled nowhere else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign btn_s = sync_r[SYNC_STAGES-1];

   // Debounce state and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         db_cnt_r <= '0;
      end else begin
         state_r  <= state_nxt_s;
         db_cnt_r <= db_cnt_nxt_s;
      end
   end

   // Debounce next-state logic; counter holds at its terminal value once a level is accepted
   always_comb begin
      state_nxt_s  = state_r;
      db_cnt_nxt_s = db_cnt_r;
      press_acc_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (btn_s) begin
               state_nxt_s  = PRESS_WAIT;
               db_cnt_nxt_s = DB_ONE;
            end else begin
               db_cnt_nxt_s = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_nxt_s  = IDLE;
               db_cnt_nxt_s = '0;
            end else if (db_cnt_r == DB_MAX) begin
               state_nxt_s = PRESSED;
               press_acc_s = 1'b1;
            end else begin
               db_cnt_nxt_s = db_cnt_r + DB_ONE;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_nxt_s  = RELEASE_WAIT;
               db_cnt_nxt_s = DB_ONE;
            end else begin
               state_nxt_s = PRESSED;
            end
         end
         RELEASE_WAIT: begin
            // A bounce back high returns to PRESSED silently, so release bounce never pulses
            if (btn_s) begin
               state_nxt_s = PRESSED;
            end else if (db_cnt_r == DB_MAX) begin
               state_nxt_s  = IDLE;
               db_cnt_nxt_s = '0;
            end else begin
               db_cnt_nxt_s = db_cnt_r + DB_ONE;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            db_cnt_nxt_s = '0;
         end
      endcase
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [RPT_W-1:0] RPT_DELAY_C = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_RATE_C  = RPT_W'(REPEAT_RATE);
   localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

   logic [RPT_W-1:0] rpt_cnt_r;
   logic [RPT_W-1:0] rpt_cnt_nxt_s;
   logic             rpt_first_r;
   logic             rpt_first_nxt_s;
   logic [RPT_W-1:0] rpt_target_s;

   // Repeat counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rpt_cnt_r   <= '0;
         rpt_first_r <= 1'b0;
      end else begin
         rpt_cnt_r   <= rpt_cnt_nxt_s;
         rpt_first_r <= rpt_first_nxt_s;
      end
   end

   // rpt_cnt_r counts cycles since the last pulse; it restarts at 1 on every pulse so it never passes the target
   always_comb begin
      rpt_cnt_nxt_s   = rpt_cnt_r;
      rpt_first_nxt_s = rpt_first_r;
      rpt_pulse_s     = 1'b0;
      rpt_target_s    = rpt_first_r ? RPT_RATE_C : RPT_DELAY_C;
      if (press_acc_s) begin
         rpt_cnt_nxt_s   = RPT_ONE;
         rpt_first_nxt_s = 1'b0;
      end else if (state_nxt_s == IDLE) begin
         rpt_cnt_nxt_s   = '0;
         rpt_first_nxt_s = 1'b0;
      end else if (state_r == PRESSED) begin
         if (rpt_cnt_r == rpt_target_s) begin
            rpt_pulse_s     = 1'b1;
            rpt_cnt_nxt_s   = RPT_ONE;
            rpt_first_nxt_s = 1'b1;
         end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + RPT_ONE;
         end
      end else begin
         rpt_cnt_nxt_s = rpt_cnt_r;
      end
   end
`else
   assign rpt_pulse_s = 1'b0;
`endif

   // Registered outputs; btn_level follows the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_out    <= 1'b0;
         btn_level <= 1'b0;
      end else begin
         en_out    <= press_acc_s | rpt_pulse_s;
         btn_level <= (state_nxt_s == PRESSED) || (state_nxt_s == RELEASE_WAIT);
      end
   end

endmodule

// File: tb/tb_button_step_gen.sv
// Self-checking bench for button_step_gen: expected pulse edges are queued per phase and popped as cycles run.
module tb_button_step_gen;

   logic clk;
   logic reset;
   logic btn_in;
   logic en_out;
   logic btn_level;

   int   n_checks;
   int   n_fail;
   int   exp_q[$];
   logic [4:0] step_cnt;

   button_step_gen #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .DB_W           (3),
      .REPEAT_DELAY   (10),
      .REPEAT_RATE    (3),
      .RPT_W          (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_in),
      .en_out   (en_out),
      .btn_level(btn_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mask(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i < hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edge k is the k-th rising edge after btn_in takes pat[k]; outputs are sampled 1 time unit after it
   task automatic run_phase(input string tag, input int n, input logic [63:0] pat, input logic [63:0] lvl);
      logic exp_en;
      for (int k = 0; k < n; k++) begin
         btn_in = pat[k];
         step();
         exp_en = (exp_q.size() > 0) && (exp_q[0] == k);
         if (exp_en) void'(exp_q.pop_front());
         check($sformatf("%s_en@%0d", tag, k), int'(en_out), int'(exp_en));
         check($sformatf("%s_lvl@%0d", tag, k), int'(btn_level), int'(lvl[k]));
         if (en_out) step_cnt = step_cnt + 5'd1;
      end
      check($sformatf("%s_missing_pulses", tag), exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      step_cnt = 5'd0;
      reset    = 1'b1;
      btn_in   = 1'b0;
      repeat (3) step();
      check("reset_en", int'(en_out), 0);
      check("reset_lvl", int'(btn_level), 0);
      reset = 1'b0;
      repeat (4) step();

      // Clean press held 20 cycles, then release
      exp_q.push_back(6);
`ifdef BTN_AUTOREPEAT_EN
      exp_q.push_back(16); exp_q.push_back(19); exp_q.push_back(22);
`endif
      run_phase("clean", 30, mask(0, 20), mask(6, 26));

      // Input bounce 1,0,1,0 then steady high from edge 4
      exp_q.push_back(10);
      run_phase("bounce", 26, mask(0, 1) | mask(2, 3) | mask(4, 16), mask(10, 22));

      // Two-cycle low glitch while pressed
      exp_q.push_back(6);
`ifdef BTN_AUTOREPEAT_EN
      exp_q.push_back(18); exp_q.push_back(21);
`endif
      run_phase("relbounce", 30, mask(0, 12) | mask(14, 20), mask(6, 26));

      // Reset three edges into PRESS_WAIT with the button held
      btn_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("midpress_en", int'(en_out), 0);
      end
      reset = 1'b1;
      #1;
      check("midpress_rst_en", int'(en_out), 0);
      check("midpress_rst_lvl", int'(btn_level), 0);
      repeat (3) step();
      check("midpress_hold_lvl", int'(btn_level), 0);
      reset = 1'b0;
      exp_q.push_back(6);
`ifdef BTN_AUTOREPEAT_EN
      exp_q.push_back(16); exp_q.push_back(19); exp_q.push_back(22);
`endif
      run_phase("postrst", 30, mask(0, 20), mask(6, 26));

      // Reset during an active pulse clears outputs without a clock edge
      btn_in = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         step();
         check($sformatf("pulserst_en@%0d", k), int'(en_out), int'(k == 6));
         check($sformatf("pulserst_lvl@%0d", k), int'(btn_level), int'(k == 6));
      end
      reset = 1'b1;
      #1;
      check("pulserst_async_en", int'(en_out), 0);
      check("pulserst_async_lvl", int'(btn_level), 0);
      repeat (2) step();
      reset  = 1'b0;
      btn_in = 1'b0;
      repeat (6) step();

      // Hold 30 cycles
      exp_q.push_back(6);
`ifdef BTN_AUTOREPEAT_EN
      exp_q.push_back(16); exp_q.push_back(19); exp_q.push_back(22);
      exp_q.push_back(25); exp_q.push_back(28); exp_q.push_back(31);
`endif
      run_phase("hold30", 40, mask(0, 30), mask(6, 36));

      // Three presses at minimum pulse spacing feeding a 5-bit step counter
      step_cnt = 5'd0;
      exp_q.push_back(6); exp_q.push_back(16); exp_q.push_back(26);
      run_phase("b2b", 36, mask(0, 5) | mask(10, 15) | mask(20, 25),
                mask(6, 11) | mask(16, 21) | mask(26, 31));
      check("b2b_count", int'(step_cnt), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
